alu_controle_ex: RTL and testbench

- ID/EX stage block that drives the ALU: decodes ALUOp/funct3/funct7[5] into the 4-bit ALUcontrol code, selects the second operand, and registers both operands and the code into the execute stage.
- Also resolves BEQ from the ALU's zero flag returned in the same cycle.
- Supports stall (hold) and flush (bubble) from the hazard unit.
- Sits between register-file/immediate-generator outputs and the ALU's valor1/valor2/ALUcontrol inputs.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_decod.sv | 41 ++++
 rtl/alu_controle_ex.sv | 109 ++++++++++
 tb/tb_alu_controle_ex.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings: ALUcontrol operation codes, ALUOp classes and the default datapath width.
package alu_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;

  // ALUcontrol codes understood by the ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // ALUOp classes produced by the main control unit
  localparam logic [1:0] OP_MEM = 2'b00;
  localparam logic [1:0] OP_BR  = 2'b01;
  localparam logic [1:0] OP_R   = 2'b10;
  localparam logic [1:0] OP_I   = 2'b11;

endpackage

// File: rtl/alu_decod.sv
// ALU operation decoder: {ALUOp, funct3, funct7[5]} -> {ALUcontrol, ilegal}. Purely combinational.
module alu_decod
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_ctrl_o,
  output logic       ilegal_o
);

  // Decode the operation; unsupported combinations fall back to ADD and raise ilegal
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    ilegal_o   = 1'b0;
    unique case (alu_op_i)
      OP_MEM: alu_ctrl_o = ALU_ADD;
      OP_BR:  alu_ctrl_o = ALU_SUB;
      OP_R: begin
        case ({funct7_5_i, funct3_i})
          4'b0_000: alu_ctrl_o = ALU_ADD;
          4'b1_000: alu_ctrl_o = ALU_SUB;
          4'b0_111: alu_ctrl_o = ALU_AND;
          4'b0_110: alu_ctrl_o = ALU_OR;
          default:  ilegal_o   = 1'b1;
        endcase
      end
      OP_I: begin
        // Immediate forms have no SUB; bit 30 belongs to the immediate
        case (funct3_i)
          3'b000:  alu_ctrl_o = ALU_ADD;
          3'b111:  alu_ctrl_o = ALU_AND;
          3'b110:  alu_ctrl_o = ALU_OR;
          default: ilegal_o   = 1'b1;
        endcase
      end
      default: ilegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_controle_ex.sv
// ID/EX stage feeding the ALU: decodes the ALU op, selects operand B, registers operands and
// code into EX, and resolves BEQ from the ALU zero flag. Supports stall (hold) and flush (bubble).
module alu_controle_ex
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            ALUSrc,
  input  logic            Branch,
  input  logic [XLEN-1:0] rs1_dado,
  input  logic [XLEN-1:0] rs2_dado,
  input  logic [XLEN-1:0] imm,
  input  logic            zero,
  output logic [XLEN-1:0] valor1,
  output logic [XLEN-1:0] valor2,
  output logic [3:0]      ALUcontrol,
  output logic            ex_valid,
  output logic            ex_ilegal,
  output logic            desvio_tomado
);

  logic [3:0]      dec_ctrl;
  logic            dec_ilegal;
  logic [XLEN-1:0] op_b;

  logic [XLEN-1:0] valor1_q, valor1_d;
  logic [XLEN-1:0] valor2_q, valor2_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic            valid_q, valid_d;
  logic            ilegal_q, ilegal_d;
  logic            branch_q, branch_d;

  alu_decod u_decod (
    .alu_op_i   (ALUOp),
    .funct3_i   (funct3),
    .funct7_5_i (funct7_5),
    .alu_ctrl_o (dec_ctrl),
    .ilegal_o   (dec_ilegal)
  );

  // Operand B mux: immediate or second register read port
  always_comb begin
    op_b = ALUSrc ? imm : rs2_dado;
  end

  // EX register next state: flush beats stall beats load
  always_comb begin
    valor1_d = valor1_q;
    valor2_d = valor2_q;
    ctrl_d   = ctrl_q;
    valid_d  = valid_q;
    ilegal_d = ilegal_q;
    branch_d = branch_q;
    if (flush) begin
      valor1_d = '0;
      valor2_d = '0;
      ctrl_d   = ALU_ADD;
      valid_d  = 1'b0;
      ilegal_d = 1'b0;
      branch_d = 1'b0;
    end else if (!stall) begin
      // Operands are captured even for bubbles; only the flags are gated by in_valid
      valor1_d = rs1_dado;
      valor2_d = op_b;
      ctrl_d   = dec_ctrl;
      valid_d  = in_valid;
      ilegal_d = dec_ilegal & in_valid;
      branch_d = Branch & in_valid;
    end
  end

  // EX register state with asynchronous clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor1_q <= '0;
      valor2_q <= '0;
      ctrl_q   <= ALU_ADD;
      valid_q  <= 1'b0;
      ilegal_q <= 1'b0;
      branch_q <= 1'b0;
    end else begin
      valor1_q <= valor1_d;
      valor2_q <= valor2_d;
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      ilegal_q <= ilegal_d;
      branch_q <= branch_d;
    end
  end

  // Outputs and same-cycle branch resolution from the ALU zero flag
  always_comb begin
    valor1        = valor1_q;
    valor2        = valor2_q;
    ALUcontrol    = ctrl_q;
    ex_valid      = valid_q;
    ex_ilegal     = ilegal_q;
    desvio_tomado = valid_q & branch_q & zero;
  end

endmodule

// File: tb/tb_alu_controle_ex.sv
// Self-checking bench for alu_controle_ex: directed scenarios plus randomized traffic against a
// behavioural model of the EX register.
module tb_alu_controle_ex;

  logic        clock = 1'b0;
  logic        reset, in_valid, stall, flush, funct7_5, ALUSrc, Branch, zero;
  logic [1:0]  ALUOp;
  logic [2:0]  funct3;
  logic [63:0] rs1_dado, rs2_dado, imm, valor1, valor2;
  logic [3:0]  ALUcontrol;
  logic        ex_valid, ex_ilegal, desvio_tomado;

  int checks = 0;
  int errors = 0;

  // Model of the EX register contents
  logic [63:0] m_v1, m_v2;
  logic [3:0]  m_code;
  logic        m_valid, m_il, m_br;

  alu_controle_ex #(.XLEN(64)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .stall         (stall),
    .flush         (flush),
    .ALUOp         (ALUOp),
    .funct3        (funct3),
    .funct7_5      (funct7_5),
    .ALUSrc        (ALUSrc),
    .Branch        (Branch),
    .rs1_dado      (rs1_dado),
    .rs2_dado      (rs2_dado),
    .imm           (imm),
    .zero          (zero),
    .valor1        (valor1),
    .valor2        (valor2),
    .ALUcontrol    (ALUcontrol),
    .ex_valid      (ex_valid),
    .ex_ilegal     (ex_ilegal),
    .desvio_tomado (desvio_tomado)
  );

  always #5 clock = ~clock;

  // Reference decode written from the instruction table
  function automatic void ref_decode(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                     output logic [3:0] code, output logic il);
    code = 4'd2;
    il   = 1'b0;
    if (op == 2'd0) code = 4'd2;
    else if (op == 2'd1) code = 4'd6;
    else if (op == 2'd2) begin
      if (f3 == 3'd0 && !f7) code = 4'd2;
      else if (f3 == 3'd0 && f7) code = 4'd6;
      else if (f3 == 3'd7 && !f7) code = 4'd0;
      else if (f3 == 3'd6 && !f7) code = 4'd1;
      else il = 1'b1;
    end else begin
      if (f3 == 3'd0) code = 4'd2;
      else if (f3 == 3'd7) code = 4'd0;
      else if (f3 == 3'd6) code = 4'd1;
      else il = 1'b1;
    end
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic src, input logic br, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] im);
    in_valid = v; ALUOp = op; funct3 = f3; funct7_5 = f7; ALUSrc = src; Branch = br;
    rs1_dado = a; rs2_dado = b; imm = im;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 2'b01, 3'd0, 1'b0, 1'b0, 1'b1, 64'd5, 64'd5, 64'd0);
    tick();
    // Reset asserted mid-stall, between edges, with zero high
    stall = 1'b1; zero = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++; if (valor1 !== 64'd0) begin errors++; $display("FAIL reset_valor1 got %h exp 0", valor1); end
    checks++; if (valor2 !== 64'd0) begin errors++; $display("FAIL reset_valor2 got %h exp 0", valor2); end
    checks++; if (ALUcontrol !== 4'b0010) begin errors++; $display("FAIL reset_ctrl got %b exp 0010", ALUcontrol); end
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ex_valid); end
    checks++; if (ex_ilegal !== 1'b0) begin errors++; $display("FAIL reset_ilegal got %b exp 0", ex_ilegal); end
    checks++; if (desvio_tomado !== 1'b0) begin errors++; $display("FAIL reset_desvio got %b exp 0", desvio_tomado); end
    #1 reset = 1'b0;
    tick();
    checks++; if (ex_valid !== 1'b0 || desvio_tomado !== 1'b0) begin
      errors++; $display("FAIL reset_hold_bubble got valid=%b desvio=%b exp 0/0", ex_valid, desvio_tomado);
    end
    stall = 1'b0; zero = 1'b0;
  endtask

  task automatic test_rtype_sub();
    drive(1'b1, 2'b10, 3'd0, 1'b1, 1'b0, 1'b0, 64'd10, 64'd3, 64'hDEAD);
    tick();
    checks++; if (ALUcontrol !== 4'b0110) begin errors++; $display("FAIL sub_ctrl got %b exp 0110", ALUcontrol); end
    checks++; if (valor1 !== 64'd10) begin errors++; $display("FAIL sub_valor1 got %0d exp 10", valor1); end
    checks++; if (valor2 !== 64'd3) begin errors++; $display("FAIL sub_valor2 got %0d exp 3", valor2); end
    checks++; if (ex_valid !== 1'b1 || ex_ilegal !== 1'b0) begin
      errors++; $display("FAIL sub_flags got valid=%b il=%b exp 1/0", ex_valid, ex_ilegal);
    end
  endtask

  task automatic test_itype();
    logic [2:0] f3s [4]   = '{3'd0, 3'd7, 3'd6, 3'd1};
    logic [3:0] codes [4] = '{4'b0010, 4'b0000, 4'b0001, 4'b0010};
    logic       ils [4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b11, f3s[i], 1'b1, 1'b1, 1'b0, 64'd99, 64'd1234, 64'hFFFF_FFFF_FFFF_FFF0);
      tick();
      checks++; if (ALUcontrol !== codes[i] || ex_ilegal !== ils[i]) begin
        errors++; $display("FAIL itype_f3_%0d got ctrl=%b il=%b exp %b/%b", f3s[i], ALUcontrol,
                           ex_ilegal, codes[i], ils[i]);
      end
      checks++; if (valor2 !== 64'hFFFF_FFFF_FFFF_FFF0) begin
        errors++; $display("FAIL itype_imm got %h exp fffffffffffffff0", valor2);
      end
    end
  endtask

  task automatic test_branch();
    drive(1'b1, 2'b01, 3'd0, 1'b0, 1'b0, 1'b1, 64'd5, 64'd5, 64'd0);
    zero = 1'b0;
    tick();
    checks++; if (ALUcontrol !== 4'b0110) begin errors++; $display("FAIL beq_ctrl got %b exp 0110", ALUcontrol); end
    zero = 1'b1; #1;
    checks++; if (desvio_tomado !== 1'b1) begin errors++; $display("FAIL beq_taken got %b exp 1", desvio_tomado); end
    zero = 1'b0; #1;
    checks++; if (desvio_tomado !== 1'b0) begin errors++; $display("FAIL beq_not_taken got %b exp 0", desvio_tomado); end
    flush = 1'b1;
    tick();
    flush = 1'b0; zero = 1'b1; #1;
    checks++; if (desvio_tomado !== 1'b0 || ex_valid !== 1'b0) begin
      errors++; $display("FAIL beq_flush got desvio=%b valid=%b exp 0/0", desvio_tomado, ex_valid);
    end
    // Branch with a non-branch ALUOp uses the decoded op without error
    drive(1'b1, 2'b10, 3'd7, 1'b0, 1'b0, 1'b1, 64'd1, 64'd2, 64'd0);
    tick();
    checks++; if (ALUcontrol !== 4'b0000 || ex_ilegal !== 1'b0 || desvio_tomado !== 1'b1) begin
      errors++; $display("FAIL branch_odd_op got ctrl=%b il=%b desvio=%b exp 0000/0/1", ALUcontrol,
                         ex_ilegal, desvio_tomado);
    end
    zero = 1'b0;
  endtask

  task automatic test_stall();
    drive(1'b1, 2'b10, 3'd0, 1'b0, 1'b0, 1'b0, 64'd7, 64'd8, 64'd0);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b10, 3'd7, 1'b0, 1'b1, 1'b0, 64'($urandom), 64'($urandom), 64'($urandom));
      tick();
      checks++; if (ALUcontrol !== 4'b0010 || valor1 !== 64'd7 || valor2 !== 64'd8 || ex_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold_%0d got %b/%0d/%0d/%b exp 0010/7/8/1", i, ALUcontrol,
                           valor1, valor2, ex_valid);
      end
    end
    flush = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b0 || valor1 !== 64'd0 || ALUcontrol !== 4'b0010) begin
      errors++; $display("FAIL stall_flush got valid=%b v1=%0d ctrl=%b exp 0/0/0010", ex_valid,
                         valor1, ALUcontrol);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] f3s [5]   = '{3'd7, 3'd6, 3'd0, 3'd2, 3'd0};
    logic       vs [5]    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] codes [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0010, 4'b0010};
    for (int i = 0; i < 5; i++) begin
      drive(vs[i], 2'b10, f3s[i], 1'b0, 1'b0, 1'b0, 64'(i), 64'(i + 10), 64'd0);
      tick();
      checks++; if (ex_valid !== vs[i] || ex_ilegal !== 1'b0 || (vs[i] && ALUcontrol !== codes[i])) begin
        errors++; $display("FAIL b2b_%0d got valid=%b il=%b ctrl=%b exp %b/0/%b", i, ex_valid,
                           ex_ilegal, ALUcontrol, vs[i], codes[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] dcode;
    logic       dil;
    m_v1 = valor1; m_v2 = valor2; m_code = ALUcontrol; m_valid = ex_valid; m_il = ex_ilegal;
    m_br = 1'b0;
    // Start from a known bubble so the hidden branch flag is known
    flush = 1'b1; tick(); flush = 1'b0;
    m_v1 = '0; m_v2 = '0; m_code = 4'd2; m_valid = 1'b0; m_il = 1'b0;
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom), 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);
      ref_decode(ALUOp, funct3, funct7_5, dcode, dil);
      if (flush) begin
        m_v1 = '0; m_v2 = '0; m_code = 4'd2; m_valid = 1'b0; m_il = 1'b0; m_br = 1'b0;
      end else if (!stall) begin
        m_v1 = rs1_dado; m_v2 = ALUSrc ? imm : rs2_dado; m_code = dcode;
        m_valid = in_valid; m_il = dil && in_valid; m_br = Branch && in_valid;
      end
      tick();
      checks++; if (ALUcontrol !== m_code || valor1 !== m_v1 || valor2 !== m_v2 ||
                    ex_valid !== m_valid || ex_ilegal !== m_il) begin
        errors++; $display("FAIL rand_%0d got ctrl=%b v1=%h v2=%h val=%b il=%b exp %b/%h/%h/%b/%b",
                           n, ALUcontrol, valor1, valor2, ex_valid, ex_ilegal, m_code, m_v1, m_v2,
                           m_valid, m_il);
      end
      zero = 1'($urandom); #1;
      checks++; if (desvio_tomado !== (m_valid && m_br && zero)) begin
        errors++; $display("FAIL rand_desvio_%0d got %b exp %b", n, desvio_tomado,
                           m_valid && m_br && zero);
      end
    end
    stall = 1'b0; flush = 1'b0; zero = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; zero = 1'b0;
    drive(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
    #12;
    test_reset();
    test_rtype_sub();
    test_itype();
    test_branch();
    test_stall();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
